mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port instruction/data memory between N requesters: data load/store (0), instruction fetch (1), debug/loader (2).
//  Only one access is in flight at a time; fixed priority plus aging prevents starvation.
//  Sits between the processor's fetch and execute units and the memory block.
// PARAMETERS
//  N        3   number of requesters; index 0 has highest base priority
//  AW       12  address width
//  DW       32  data width
//  RD_LAT   1   memory read latency in cycles after the address cycle, 1..7
//  STARVE   4   lost arbitrations after which a requester is promoted, 1..15
// PORTS
//  clock      in   1      rising-edge clock
//  reset_n    in   1      asynchronous active-low reset
//  req        in   N      per-requester access request, held until gnt
//  we         in   N      per-requester 1=write, 0=read
//  addr       in   N*AW   per-requester address; slice i = [i*AW +: AW]
//  wdata      in   N*DW   per-requester write data; slice i = [i*DW +: DW]
//  gnt        out  N      one-hot pulse: request accepted, may drop or change req
//  done       out  N      one-hot pulse: access complete; rdata valid if read
//  rdata      out  DW     read data; holds until the next read completes
//  busy       out  1      access in flight, i.e. state is not IDLE
//  mem_addr   out  AW     memory address; holds between accesses
//  mem_write  out  1      memory write strobe
//  mem_wdata  out  DW     memory write data; holds between accesses
//  mem_rdata  in   DW     memory read data
// BEHAVIOUR
//  Reset: gnt=0, done=0, rdata=0, busy=0, mem_addr=0, mem_wdata=0, mem_write=0, age counters=0, state=IDLE.
//  Reset mid-access abandons the access: no gnt or done, and mem_write drops immediately.
//  States:
//   IDLE  -> ISSUE when any req is high
//   ISSUE -> WAIT for a read; -> DONE for a write
//   WAIT  lasts RD_LAT cycles, then -> DONE
//   DONE  -> ISSUE if any req is high; else -> IDLE
//  Arbitration is evaluated only at edges leaving IDLE or DONE.
//  The winner's we/addr/wdata are registered into mem_*, and the winner index is latched.
//  ISSUE (exactly one cycle): gnt[w]=1. mem_write=1 only if it is a write.
//  WAIT: rdata <= mem_rdata at the edge ending the last WAIT cycle.
//  DONE (exactly one cycle): done[w]=1.
//  Latency from the req-sampling edge: write gnt +1 cycle, done +2 cycles; read gnt +1 cycle, done +2+RD_LAT cycles.
//  Back-to-back: DONE->ISSUE gives throughput of one write per 2 cycles and one read per 2+RD_LAT cycles.
//  Winner selection: requesters with age==STARVE beat all others; within a class, the lowest index wins.
//  Age counter i:
//   +1 (saturating at STARVE) at each arbitration edge where req[i]=1 and i loses
//   cleared when i wins or when req[i]=0 at an arbitration edge
//  A latched access completes even if its req drops before gnt.
//  A requester must not change addr/we/wdata while req=1 and gnt=0.
//  req changes during ISSUE/WAIT are ignored until the next arbitration edge.
//  Simultaneous done[i] and new req[i]: the new req is eligible at that same DONE edge.
//  gnt and done are never high in the same cycle; at most one bit of each is set.
//  Address/data are passed through unmodified; no wrap or width arithmetic.
// STRUCTURE
//  mem_arb_pkg holds:
//   state encoding: IDLE/ISSUE/WAIT/DONE
//   default AW/DW
//   requester index constants REQ_DATA=0, REQ_FETCH=1, REQ_DEBUG=2
//  Sub-module arb_age_picker (N, STARVE): age counters plus winner select.
//   Outputs a one-hot winner and an any-request flag; the parent holds the FSM and datapath registers.
// TESTING
//  1. Reset, single read: req[1]=1, addr1=0xFC0, mem holds 0x0000_1234.
//     -> gnt[1] next cycle, mem_addr=0xFC0, done[1] 3 cycles after sampling, rdata=0x0000_1234.
//  2. Single write: req[0]=1, we[0]=1, addr0=0x010, wdata0=0xDEADBEEF.
//     -> exactly one cycle of mem_write=1 with those values; done[0] 2 cycles after sampling; rdata unchanged.
//  3. Contention: req[0] and req[1] high continuously with reads.
//     -> grants 0,0,0,0, then 1 once age hits STARVE=4, then 0 again; done order matches gnt order.
//  4. Back-to-back: req[2] and req[0] both writes, asserted together.
//     -> gnt[0], done[0], and gnt[2] in the cycle right after done[0]; busy never drops between them.
//  5. Reset mid-read: assert reset_n=0 during WAIT.
//     -> all outputs 0 at once, no done pulse; the first access after release works per scenario 1.
//  6. req[1] dropped during WAIT while another read is pending.
//     -> done[1] still issued; no further gnt[1]; the pending requester is served next.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
// State encoding, default widths and requester indices.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } arb_state_e;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 32;

  localparam int REQ_DATA  = 0;
  localparam int REQ_FETCH = 1;
  localparam int REQ_DEBUG = 2;

  // Age counters hold values 0..15.
  localparam int AGE_W = 4;

endpackage

// File: rtl/arb_age_picker.sv
// Age counters plus winner select for the memory port arbiter.
// Ports: clk/rst_n, i_arb (arbitration edge), i_req; o_win one-hot, o_any.
module arb_age_picker
  import mem_arb_pkg::*;
#(
  parameter int N      = 3,
  parameter int STARVE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_arb,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_win,
  output logic         o_any
);

  logic [AGE_W-1:0] r_age [N];
  logic [N-1:0]     w_starve;
  logic [N-1:0]     w_pool;

  always_comb begin
    w_starve = '0;
    for (int i = 0; i < N; i++) begin
      w_starve[i] = i_req[i] &&
                    (r_age[i] == AGE_W'(STARVE));
    end
    // Starved requesters form their own class.
    w_pool = (|w_starve) ? w_starve : i_req;
    // Isolate lowest set bit: lowest index wins.
    o_win  = w_pool & (~w_pool + 1'b1);
  end

  assign o_any = |i_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_age[i] <= '0;
      end
    end else if (i_arb) begin
      for (int i = 0; i < N; i++) begin
        if (!i_req[i] || o_win[i]) begin
          r_age[i] <= '0;
        end else if (r_age[i] != AGE_W'(STARVE)) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between N requesters, one access at a time.
// Ports: req/we/addr/wdata in, gnt/done/rdata/busy out, mem_* to memory.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N      = 3,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1,
  parameter int STARVE = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    we,
  input  logic [N*AW-1:0] addr,
  input  logic [N*DW-1:0] wdata,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_write,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  arb_state_e    r_state;
  logic [N-1:0]  r_win;
  logic [N-1:0]  r_gnt;
  logic [N-1:0]  r_done;
  logic          r_we;
  logic [2:0]    r_cnt;
  logic [DW-1:0] r_rdata;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_write;
  logic [DW-1:0] r_mem_wdata;

  logic          w_arb;
  logic [N-1:0]  w_win;
  logic          w_any;
  logic [IW-1:0] w_idx;

  assign w_arb = (r_state == S_IDLE) ||
                 (r_state == S_DONE);

  arb_age_picker #(
    .N      (N),
    .STARVE (STARVE)
  ) u_pick (
    .clk   (clock),
    .rst_n (reset_n),
    .i_arb (w_arb),
    .i_req (req),
    .o_win (w_win),
    .o_any (w_any)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_win[i]) begin
        w_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_win       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_we        <= 1'b0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_write <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_gnt       <= '0;
      r_done      <= '0;
      r_mem_write <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (w_any) begin
            r_state     <= S_ISSUE;
            r_win       <= w_win;
            r_gnt       <= w_win;
            r_we        <= we[w_idx];
            r_mem_write <= we[w_idx];
            r_mem_addr  <= addr[w_idx*AW +: AW];
            r_mem_wdata <= wdata[w_idx*DW +: DW];
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
          if (r_we) begin
            r_state <= S_DONE;
            r_done  <= r_win;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'(RD_LAT - 1)) begin
            r_rdata <= mem_rdata;
            r_state <= S_DONE;
            r_done  <= r_win;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign busy      = (r_state != S_IDLE);
  assign mem_addr  = r_mem_addr;
  assign mem_write = r_mem_write;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Transaction-level reference model against random and directed traffic.
module tb_mem_port_arbiter;

  localparam int N      = 3;
  localparam int AW     = 12;
  localparam int DW     = 32;
  localparam int RD_LAT = 1;
  localparam int STARVE = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic [AW-1:0]   mem_addr;
  logic            mem_write;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  mem_port_arbiter #(
    .N(N), .AW(AW), .DW(DW),
    .RD_LAT(RD_LAT), .STARVE(STARVE)
  ) dut (
    .clock     (clk),
    .reset_n   (rst_n),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
    return (a == 12'hFC0) ? 32'h0000_1234 : {8'h5A, 12'h0, a};
  endfunction

  // Synchronous RAM: one cycle read latency.
  logic [DW-1:0] ram [1<<AW];
  bit            ram_v [1<<AW];
  always @(posedge clk) begin
    if (mem_write) begin
      ram[mem_addr]   <= mem_wdata;
      ram_v[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_v[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  // Reference model state
  logic [DW-1:0] sh [logic [AW-1:0]];
  int            age [N];
  int            nxt_arb, t_arb, t_done, cur_w;
  bit            has_cur, cur_we;
  logic [AW-1:0] cur_addr, m_maddr;
  logic [DW-1:0] cur_wd, m_mwdata, m_rdata;
  logic [N-1:0]  eg, ed;
  bit            eb, emw;
  bit            hold [N];
  int            gq [$];

  function automatic logic [DW-1:0] sh_rd(logic [AW-1:0] a);
    return sh.exists(a) ? sh[a] : init_val(a);
  endfunction

  task automatic model_step();
    int w;
    cyc++;
    if (!rst_n) begin
      has_cur  = 0;
      for (int i = 0; i < N; i++) age[i] = 0;
      nxt_arb  = cyc + 1;
      m_rdata  = '0;
      m_maddr  = '0;
      m_mwdata = '0;
    end else begin
      if (has_cur && cur_we && cyc == t_arb + 1)
        sh[cur_addr] = cur_wd;
      if (has_cur && !cur_we && cyc == t_done)
        m_rdata = sh_rd(cur_addr);
      if (cyc == nxt_arb) begin
        if (req == '0) begin
          for (int i = 0; i < N; i++) age[i] = 0;
          nxt_arb = cyc + 1;
        end else begin
          w = -1;
          for (int i = 0; i < N; i++)
            if (w < 0 && req[i] && age[i] == STARVE) w = i;
          for (int i = 0; i < N; i++)
            if (w < 0 && req[i]) w = i;
          for (int i = 0; i < N; i++) begin
            if (i == w || !req[i]) age[i] = 0;
            else if (age[i] < STARVE) age[i]++;
          end
          has_cur  = 1;
          cur_w    = w;
          cur_we   = we[w];
          cur_addr = addr[w*AW +: AW];
          cur_wd   = wdata[w*DW +: DW];
          m_maddr  = cur_addr;
          m_mwdata = cur_wd;
          t_arb    = cyc;
          t_done   = cur_we ? cyc + 1 : cyc + 1 + RD_LAT;
          nxt_arb  = t_done + 1;
        end
      end
    end
    eg  = (has_cur && cyc == t_arb)  ? N'(1 << cur_w) : '0;
    ed  = (has_cur && cyc == t_done) ? N'(1 << cur_w) : '0;
    eb  = has_cur && cyc >= t_arb && cyc <= t_done;
    emw = (eg != '0) && cur_we;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    chk("ctl", {gnt, done, busy, mem_write}, {eg, ed, eb, emw});
    chk("rdata", rdata, m_rdata);
    chk("maddr", mem_addr, m_maddr);
    chk("mwdata", mem_wdata, m_mwdata);
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        gq.push_back(i);
        if (!hold[i]) req[i] = 1'b0;
      end
    end
  endtask

  task automatic raise(input int i, input bit w,
                       input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (!busy && req == '0) break;
    end
    chk("drain", {busy, req}, '0);
  endtask

  task automatic hit_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_ctl", {gnt, done, busy, mem_write, mem_addr}, '0);
    chk("rst_dat", {rdata, mem_wdata}, '0);
    cycle();
    rst_n = 1'b1;
  endtask

  int s3e [6] = '{0, 0, 0, 0, 1, 0};

  initial begin
    for (int i = 0; i < N; i++) hold[i] = 0;
    repeat (2) cycle();
    chk("reset", {gnt, done, busy, mem_write, mem_addr}, '0);
    rst_n = 1'b1;

    // single read
    raise(1, 0, 12'hFC0, '0);
    repeat (5) cycle();
    chk("s1_rdata", rdata, 32'h0000_1234);

    // single write, then read it back
    raise(0, 1, 12'h010, 32'hDEAD_BEEF);
    repeat (4) cycle();
    chk("s2_rdata", rdata, 32'h0000_1234);
    raise(2, 0, 12'h010, '0);
    drain();
    chk("s2_back", rdata, 32'hDEAD_BEEF);

    // contention with aging
    gq.delete();
    hold[0] = 1;
    hold[1] = 1;
    raise(0, 0, 12'h020, '0);
    raise(1, 0, 12'h021, '0);
    repeat (24) cycle();
    hold[0] = 0;
    hold[1] = 0;
    drain();
    chk("s3_cnt", 64'(gq.size() >= 6), 1);
    for (int k = 0; k < 6; k++)
      if (k < gq.size()) chk("s3_ord", gq[k], s3e[k]);

    // back-to-back writes
    raise(2, 1, 12'h030, 32'h2222_0000);
    raise(0, 1, 12'h031, 32'h0000_0001);
    drain();

    // reset during WAIT
    raise(1, 0, 12'hFC0, '0);
    cycle();
    cycle();
    hit_reset();
    raise(1, 0, 12'hFC0, '0);
    drain();
    chk("s5_rdata", rdata, 32'h0000_1234);

    // req drop during WAIT with another read pending
    gq.delete();
    raise(1, 0, 12'h040, '0);
    cycle();
    raise(2, 0, 12'h041, '0);
    drain();
    chk("s6_ord", 64'(gq.size() == 2 && gq[0] == 1 && gq[1] == 2), 1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        hold[i] = ($urandom_range(0, 5) == 0);
        if (!req[i] && $urandom_range(0, 3) == 0)
          raise(i, 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 15)), $urandom);
      end
      if ($urandom_range(0, 399) == 0) hit_reset();
    end
    for (int i = 0; i < N; i++) hold[i] = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
